// File: rtl/stopwatch_pkg.sv
// ----------------------------------------------------------------------------
// stopwatch_pkg
// Shared constants for the stopwatch control sequencer, the BCD counter
// datapath and the display, so that all of them decode `state` the same way.
//   sw_state_t      : 2-bit state code carried on the control interface
//   ST_*            : state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3)
//   *_DEFAULT       : default divider / debounce lengths for a 100 MHz clock
//   BTN_*           : bit positions of the three buttons in internal vectors
//   cnt_width()     : counter width for a modulo-n counter (at least 1 bit)
// ----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef logic [1:0] sw_state_t;

    localparam sw_state_t ST_IDLE  = 2'd0;
    localparam sw_state_t ST_RUN   = 2'd1;
    localparam sw_state_t ST_PAUSE = 2'd2;
    localparam sw_state_t ST_LAP   = 2'd3;

    // 100 MHz clock -> 100 Hz count tick, 10 ms debounce window
    localparam int TICK_DIV_DEFAULT     = 1_000_000;
    localparam int DEBOUNCE_CYC_DEFAULT = 1_000_000;

    localparam int BTN_STARTSTOP = 0;
    localparam int BTN_CLEAR     = 1;
    localparam int BTN_LAP       = 2;
    localparam int NUM_BTN       = 3;

    // Width of a counter that runs 0..n-1; a 1-bit floor keeps n=1 legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl_if
// Groups the raw button inputs and the control outputs of stopwatch_ctrl.
//   btn_startstop, btn_clear, btn_lap : raw asynchronous buttons, active-high
//   tick_en   : 1-cycle count enable, every TICK_DIV cycles while counting
//   cnt_clear : 1-cycle pulse, datapath zeroes all digits
//   disp_hold : level, display freezes the shown value (lap)
//   running   : level, 1 in RUN or LAP
//   state     : current sequencer state (see stopwatch_pkg ST_*)
// Modports:
//   master : board / datapath side (drives buttons, consumes controls)
//   slave  : the sequencer itself
// ----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic      btn_startstop;
    logic      btn_clear;
    logic      btn_lap;
    logic      tick_en;
    logic      cnt_clear;
    logic      disp_hold;
    logic      running;
    sw_state_t state;

    modport master (
        output btn_startstop, btn_clear, btn_lap,
        input  tick_en, cnt_clear, disp_hold, running, state
    );

    modport slave (
        input  btn_startstop, btn_clear, btn_lap,
        output tick_en, cnt_clear, disp_hold, running, state
    );

endinterface

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push-button: 2-flop synchroniser, debounce counter and a
// single-cycle press pulse on the rising edge of the debounced level.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   btn_raw : raw asynchronous button, active-high
//   press   : 1-cycle pulse, DEBOUNCE_CYC+3 cycles after btn_raw is stably high
// A button that is held while reset is released does not produce a press: the
// debouncer stays disarmed until it has seen DEBOUNCE_CYC consecutive low
// samples, so the user has to release and press again.
// ----------------------------------------------------------------------------
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [1:0]    fill_reg;      // marks when sync2_reg holds a real sample
    logic          armed_reg;
    logic          armed_next;
    logic          level_reg;
    logic          level_next;
    logic          level_d_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next   = cnt_reg;
        armed_next = armed_reg;
        level_next = level_reg;
        if (!armed_reg) begin
            // Wait for a debounced "released" before any press can count.
            if (fill_reg[1] && !sync2_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    armed_next = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                cnt_next = '0;
            end
        end else if (sync2_reg != level_reg) begin
            // A run of samples that all differ from the accepted level; any
            // sample equal to the level drops into the else branch below.
            if (cnt_reg == CNT_LAST) begin
                level_next = sync2_reg;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end else begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            fill_reg    <= 2'b00;
            armed_reg   <= 1'b0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            press_reg   <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync1_reg   <= btn_raw;
            sync2_reg   <= sync1_reg;
            fill_reg    <= {fill_reg[0], 1'b1};
            armed_reg   <= armed_next;
            level_reg   <= level_next;
            level_d_reg <= level_reg;
            press_reg   <= level_reg & ~level_d_reg;
            cnt_reg     <= cnt_next;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl
// Control sequencer for the stopwatch BCD counter/display datapath.
// Debounces the three buttons, runs the IDLE/RUN/PAUSE/LAP state machine and
// generates the count tick, the counter clear pulse and the display hold.
//   clk   : system clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   sw    : stopwatch_ctrl_if.slave (buttons in, tick_en/cnt_clear/
//           disp_hold/running/state out; all outputs registered)
// Parameters:
//   TICK_DIV     : clk cycles per count tick
//   DEBOUNCE_CYC : stable synchronised samples needed to accept a button level
// ----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input logic             clk,
    input logic             rst_n,
    stopwatch_ctrl_if.slave sw
);

    localparam int            DW       = cnt_width(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw[BTN_STARTSTOP] = sw.btn_startstop;
    assign btn_raw[BTN_CLEAR]     = sw.btn_clear;
    assign btn_raw[BTN_LAP]       = sw.btn_lap;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_debounce (
                .clk     (clk),
                .rst_n   (rst_n),
                .btn_raw (btn_raw[gi]),
                .press   (press[gi])
            );
        end
    endgenerate

    // Coinciding presses: clear beats startstop beats lap, and the losers are
    // dropped even when the winner has no effect in the current state.
    logic do_clear;
    logic do_ss;
    logic do_lap;

    assign do_clear = press[BTN_CLEAR];
    assign do_ss    = press[BTN_STARTSTOP] & ~press[BTN_CLEAR];
    assign do_lap   = press[BTN_LAP] & ~press[BTN_STARTSTOP] & ~press[BTN_CLEAR];

    sw_state_t     state_reg;
    sw_state_t     state_next;
    logic [DW-1:0] div_reg;
    logic [DW-1:0] div_next;
    logic          tick_reg;
    logic          tick_next;
    logic          clear_reg;
    logic          clear_next;
    logic          hold_reg;
    logic          running_reg;
    logic          counting;
    logic          staying;
    logic          div_wrap;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (do_ss) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (do_ss)       state_next = ST_PAUSE;
                else if (do_lap) state_next = ST_LAP;
            end
            ST_LAP: begin
                if (do_ss)       state_next = ST_PAUSE;
                else if (do_lap) state_next = ST_RUN;
            end
            ST_PAUSE: begin
                if (do_clear)   state_next = ST_IDLE;
                else if (do_ss) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign counting = (state_reg == ST_RUN) || (state_reg == ST_LAP);
    assign staying  = (state_next == ST_RUN) || (state_next == ST_LAP);
    assign div_wrap = (div_reg == DIV_LAST);

    // The divider advances on every edge spent in RUN/LAP, including the one
    // that leaves; a wrap on that leaving edge is swallowed rather than
    // issuing a tick to a datapath that is about to stop counting.
    always_comb begin
        div_next = div_reg;
        if (counting) begin
            div_next = div_wrap ? '0 : div_reg + 1'b1;
        end else if ((state_reg == ST_IDLE) || (state_next == ST_IDLE)) begin
            div_next = '0;
        end
    end

    assign tick_next  = counting & staying & div_wrap;
    assign clear_next = (state_reg == ST_PAUSE) && (state_next == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            div_reg     <= '0;
            tick_reg    <= 1'b0;
            clear_reg   <= 1'b1;   // datapath starts from zero after reset
            hold_reg    <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            tick_reg    <= tick_next;
            clear_reg   <= clear_next;
            hold_reg    <= (state_next == ST_LAP);
            running_reg <= staying;
        end
    end

    assign sw.state     = state_reg;
    assign sw.tick_en   = tick_reg;
    assign sw.cnt_clear = clear_reg;
    assign sw.disp_hold = hold_reg;
    assign sw.running   = running_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed scenarios followed by random button traffic. A behavioural model
// schedules each accepted press at a fixed latency after the raw press, applies
// the state table with clear > startstop > lap priority, and derives ticks from
// the total number of counting cycles since the last IDLE.
// ----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int TD  = 5;        // TICK_DIV
    localparam int DB  = 4;        // DEBOUNCE_CYC
    localparam int LAT = DB + 4;   // raw raised after edge c -> FSM acts at edge c+LAT

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    localparam int B_SS  = 0;
    localparam int B_CLR = 1;
    localparam int B_LAP = 2;
    localparam logic [2:0] M_SS  = 3'b001;
    localparam logic [2:0] M_CLR = 3'b010;
    localparam logic [2:0] M_LAP = 3'b100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .TICK_DIV     (TD),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_if.slave)
    );

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    bit [2:0] sched [0:8191];

    int   m_state = S_IDLE;
    int   m_runc  = 0;
    logic m_tick  = 1'b0;
    logic m_clear = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic [2:0] m);
        sw_if.btn_startstop = m[B_SS];
        sw_if.btn_clear     = m[B_CLR];
        sw_if.btn_lap       = m[B_LAP];
    endtask

    // One clock: advance the model, then compare every output 1 ns later.
    task automatic step();
        bit [2:0] act;
        int       prev;
        int       nxt;
        bit       cnt_now;
        @(posedge clk);
        cyc++;
        act = (cyc < 8192) ? sched[cyc] : 3'b000;
        if (!rst_n) begin
            m_state = S_IDLE;
            m_runc  = 0;
            m_tick  = 1'b0;
            m_clear = 1'b1;
        end else begin
            prev = m_state;
            nxt  = prev;
            if (act[B_CLR]) begin
                if (prev == S_PAUSE) nxt = S_IDLE;
            end else if (act[B_SS]) begin
                nxt = (prev == S_IDLE || prev == S_PAUSE) ? S_RUN : S_PAUSE;
            end else if (act[B_LAP]) begin
                if (prev == S_RUN)      nxt = S_LAP;
                else if (prev == S_LAP) nxt = S_RUN;
            end
            cnt_now = (prev == S_RUN || prev == S_LAP);
            if (cnt_now) m_runc++;
            if (nxt == S_IDLE) m_runc = 0;
            m_tick  = cnt_now && (nxt == S_RUN || nxt == S_LAP) && (m_runc % TD == 0);
            m_clear = (prev == S_PAUSE) && (nxt == S_IDLE);
            m_state = nxt;
        end
        #1;
        chk("state",     sw_if.state,     m_state);
        chk("tick_en",   sw_if.tick_en,   m_tick);
        chk("cnt_clear", sw_if.cnt_clear, m_clear);
        chk("disp_hold", sw_if.disp_hold, m_state == S_LAP);
        chk("running",   sw_if.running,   m_state == S_RUN || m_state == S_LAP);
    endtask

    // Clean press: raise now, hold for `hold` cycles, release. The model
    // expects the action LAT edges after the raise.
    task automatic do_press(input logic [2:0] mask, input int hold);
        if (cyc + LAT < 8192) sched[cyc + LAT] = sched[cyc + LAT] | mask;
        drive(mask);
        repeat (hold) step();
        drive(3'b000);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    int       e;
    int       r;
    int       nt;
    logic [2:0] m;
    int       h;

    initial begin
        // 1: reset, with lap held through it
        drive(3'b000);
        sw_if.btn_lap = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_state", sw_if.state, S_IDLE);
        chk("rst_clear", sw_if.cnt_clear, 1);
        chk("rst_tick",  sw_if.tick_en, 0);
        chk("rst_hold",  sw_if.disp_hold, 0);
        step();
        chk("clear_drop", sw_if.cnt_clear, 0);
        repeat (11) step();
        sw_if.btn_lap = 1'b0;
        repeat (12) step();
        chk("held_lap_ignored", sw_if.state, S_IDLE);

        // 2: bouncing startstop, then a stable press
        for (int i = 0; i < 3; i++) begin
            sw_if.btn_startstop = 1'b1;
            repeat (2) step();
            sw_if.btn_startstop = 1'b0;
            repeat (2) step();
        end
        do_press(M_SS, LAT - 1);
        chk("bounce_not_early", sw_if.state, S_IDLE);
        step();
        chk("bounce_run", sw_if.state, S_RUN);
        e = cyc;

        // 3: tick cadence from RUN entry
        nt = 0;
        for (int k = 1; k <= 27; k++) begin
            step();
            chk("tick_phase", sw_if.tick_en, (k % TD) == 0);
            if (sw_if.tick_en) nt++;
        end
        chk("tick_count", nt, 5);

        // 4: pause 2 cycles after the tick at e+35, resume later
        wait_until(e + 37 - LAT);
        do_press(M_SS, DB + 1);
        wait_until(e + 37);
        chk("pause_state", sw_if.state, S_PAUSE);
        nt = 0;
        repeat (50) begin
            step();
            if (sw_if.tick_en) nt++;
        end
        chk("pause_no_tick", nt, 0);
        r = cyc + LAT;
        do_press(M_SS, DB + 1);
        wait_until(r);
        chk("resume_state", sw_if.state, S_RUN);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("resume_tick", sw_if.tick_en, k == 3);
        end

        // 5: lap freeze and release
        r = cyc + LAT;
        do_press(M_LAP, DB + 1);
        wait_until(r);
        chk("lap_state", sw_if.state, S_LAP);
        chk("lap_hold", sw_if.disp_hold, 1);
        nt = 0;
        repeat (10) begin
            step();
            if (sw_if.tick_en) nt++;
        end
        chk("lap_ticks", nt, 2);
        r = cyc + LAT;
        do_press(M_LAP, DB + 2);
        wait_until(r);
        chk("unlap_state", sw_if.state, S_RUN);
        chk("unlap_hold", sw_if.disp_hold, 0);

        // 6: clear ignored in RUN; clear+startstop together in PAUSE
        r = cyc + LAT;
        do_press(M_CLR, DB + 1);
        wait_until(r);
        step();
        chk("clear_in_run", sw_if.state, S_RUN);
        repeat (6) step();
        r = cyc + LAT;
        do_press(M_SS, DB + 1);
        wait_until(r);
        chk("pause_again", sw_if.state, S_PAUSE);
        repeat (8) step();
        r = cyc + LAT;
        do_press(M_SS | M_CLR, DB + 1);
        wait_until(r);
        chk("clear_to_idle", sw_if.state, S_IDLE);
        chk("clear_pulse", sw_if.cnt_clear, 1);
        step();
        chk("clear_pulse_end", sw_if.cnt_clear, 0);
        repeat (12) step();
        chk("ss_dropped", sw_if.state, S_IDLE);

        // Random traffic: clean presses (possibly several buttons at once),
        // glitches shorter than the debounce window, one mid-run reset.
        for (int s = 0; s < 60; s++) begin
            if (s == 30) begin
                rst_n = 1'b0;
                repeat (2) step();
                rst_n = 1'b1;
                repeat (12) step();
            end
            m = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 3) == 0) begin
                h = $urandom_range(1, DB - 1);
                drive(m);
                repeat (h) step();
                drive(3'b000);
            end else begin
                do_press(m, $urandom_range(DB, DB + 4));
            end
            repeat ($urandom_range(DB + 3, DB + 10)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
